// File: rtl/equation_checker.sv
// equation_checker: generates one pseudo-random quiz equation, displays it,
// and checks switch answers submitted with the Go key. Produces a one-cycle
// correct pulse when the equation is finished and a sticky Wrong flag.
module equation_checker #(
   parameter logic [7:0] SEED      = 8'hA5,
   parameter int         MAX_TRIES = 3
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       startEq,
   input  logic       Go,
   input  logic [6:0] DataIn,
   input  logic       Clear,
   output logic [3:0] OperandA,
   output logic [3:0] OperandB,
   output logic [1:0] Op,
   output logic [6:0] Answer,
   output logic       EqValid,
   output logic [2:0] Tries,
   output logic       correct,
   output logic       Wrong
);

   localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GEN   = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_PASS  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t     state_q;
   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;
   logic [2:0] sync_q;
   logic [2:0] sync_d;
   logic [6:0] ans_in_q;

   logic       go_edge;
   logic [3:0] raw_a;
   logic [3:0] raw_b;
   logic [1:0] gen_op;
   logic [3:0] gen_a;
   logic [3:0] gen_b;
   logic [6:0] gen_ans;
   logic [2:0] tries_inc;

   // Fold a 4-bit nibble into a decimal digit 0..9.
   function automatic logic [3:0] reduce_digit(input logic [3:0] x);
      return (x < 4'd10) ? x : (x - 4'd10);
   endfunction

   // Next LFSR value and Go synchroniser shift.
   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      sync_d = {sync_q[1:0], Go};
   end

   // LFSR free-runs from reset; Go passes through a two-flop sync plus one edge flop.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         lfsr_q <= SEED;
         sync_q <= 3'b000;
      end else begin
         lfsr_q <= lfsr_d;
         sync_q <= sync_d;
      end
   end

   // Equation candidate from the current LFSR value; subtraction is ordered so the result is non-negative.
   always_comb begin
      go_edge   = sync_q[1] & ~sync_q[2];
      raw_a     = reduce_digit(lfsr_q[3:0]);
      raw_b     = reduce_digit(lfsr_q[7:4]);
      gen_op    = {lfsr_q[0] ^ lfsr_q[6], lfsr_q[2]};
      if (gen_op == 2'd3) begin
         gen_op = OP_ADD;
      end
      gen_a     = raw_a;
      gen_b     = raw_b;
      if ((gen_op == OP_SUB) && (raw_a < raw_b)) begin
         gen_a = raw_b;
         gen_b = raw_a;
      end
      case (gen_op)
         OP_SUB:  gen_ans = {3'b000, gen_a} - {3'b000, gen_b};
         OP_MUL:  gen_ans = {3'b000, gen_a} * {3'b000, gen_b};
         default: gen_ans = {3'b000, gen_a} + {3'b000, gen_b};
      endcase
      tries_inc = Tries + 3'd1;
   end

   // Equation FSM with all outputs registered; abort (startEq low) outranks Go and CHECK results.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         OperandA <= 4'd0;
         OperandB <= 4'd0;
         Op       <= 2'd0;
         Answer   <= 7'd0;
         EqValid  <= 1'b0;
         Tries    <= 3'd0;
         correct  <= 1'b0;
         Wrong    <= 1'b0;
         ans_in_q <= 7'd0;
      end else begin
         correct <= 1'b0;
         // A wrong CHECK below overrides this clear in the same cycle.
         if (Clear) begin
            Wrong <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               EqValid <= 1'b0;
               if (startEq) begin
                  state_q <= S_GEN;
               end
            end
            S_GEN: begin
               if (!startEq) begin
                  state_q <= S_IDLE;
               end else begin
                  OperandA <= gen_a;
                  OperandB <= gen_b;
                  Op       <= gen_op;
                  Answer   <= gen_ans;
                  Tries    <= 3'd0;
                  EqValid  <= 1'b1;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!startEq) begin
                  EqValid <= 1'b0;
                  state_q <= S_IDLE;
               end else if (go_edge) begin
                  ans_in_q <= DataIn;
                  state_q  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (!startEq) begin
                  EqValid <= 1'b0;
                  state_q <= S_IDLE;
               end else if (ans_in_q == Answer) begin
                  correct <= 1'b1;
                  state_q <= S_PASS;
               end else begin
                  Wrong <= 1'b1;
                  Tries <= tries_inc;
                  if (tries_inc == MAX_T) begin
                     correct <= 1'b1;
                     state_q <= S_PASS;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_PASS: begin
               EqValid <= 1'b0;
               state_q <= S_DONE;
            end
            S_DONE: begin
               EqValid <= 1'b0;
               if (!startEq) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               EqValid <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_equation_checker.sv
// tb_equation_checker: table-driven and randomized bench for equation_checker.
module tb_equation_checker;

   localparam logic [7:0] SEED      = 8'hA5;
   localparam int         MAX_TRIES = 3;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       startEq;
   logic       Go;
   logic [6:0] DataIn;
   logic       Clear;
   logic [3:0] OperandA;
   logic [3:0] OperandB;
   logic [1:0] Op;
   logic [6:0] Answer;
   logic       EqValid;
   logic [2:0] Tries;
   logic       correct;
   logic       Wrong;

   equation_checker #(.SEED(SEED), .MAX_TRIES(MAX_TRIES)) dut (
      .Clock(Clock), .Reset(Reset), .startEq(startEq), .Go(Go),
      .DataIn(DataIn), .Clear(Clear), .OperandA(OperandA),
      .OperandB(OperandB), .Op(Op), .Answer(Answer), .EqValid(EqValid),
      .Tries(Tries), .correct(correct), .Wrong(Wrong)
   );

   always #5 Clock = ~Clock;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int m_lfsr;
   int exp_a, exp_b, exp_op, exp_ans;
   int m_tries;
   int m_wrong;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Next value of the LFSR, written as arithmetic on an integer.
   function automatic int lfsr_next(input int v);
      int fb;
      fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
      return ((v * 2) % 256) + fb;
   endfunction

   // Equation that a given LFSR value yields.
   function automatic void decode(input int v, output int a, output int b,
                                  output int op, output int ans, output int swapped);
      int c;
      a = (v % 16) % 10;
      b = (v / 16) % 10;
      c = 2 * ((v & 1) ^ ((v >> 6) & 1)) + ((v >> 2) & 1);
      if (c == 3) c = 0;
      op = c;
      swapped = 0;
      if (c == 1 && a < b) begin
         int t;
         t = a; a = b; b = t; swapped = 1;
      end
      if (c == 0)      ans = a + b;
      else if (c == 1) ans = a - b;
      else             ans = a * b;
   endfunction

   always @(posedge Clock or posedge Reset) begin
      if (Reset) m_lfsr <= int'(SEED);
      else       m_lfsr <= lfsr_next(m_lfsr);
   end

   // Raise startEq at a moment when the equation will satisfy pred
   // (0 = any, 1 = subtraction whose operands need swapping) and check the display.
   task automatic start_eq(input int pred);
      int a, b, op, ans, sw, nxt;
      bit found;
      found = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge Clock);
         nxt = lfsr_next(m_lfsr);
         decode(nxt, a, b, op, ans, sw);
         if (pred == 0 || (pred == 1 && sw == 1)) begin
            startEq = 1'b1;
            found = 1;
         end
      end
      chk("start_search", 32'(found), 32'd1);
      exp_a = a; exp_b = b; exp_op = op; exp_ans = ans;
      m_tries = 0;
      @(posedge Clock); #1;
      chk("gen_eqvalid_low", 32'(EqValid), 32'd0);
      @(posedge Clock); #1;
      chk("eqvalid", 32'(EqValid), 32'd1);
      chk("operand_a", 32'(OperandA), 32'(exp_a));
      chk("operand_b", 32'(OperandB), 32'(exp_b));
      chk("op", 32'(Op), 32'(exp_op));
      chk("answer", 32'(Answer), 32'(exp_ans));
      chk("tries_start", 32'(Tries), 32'd0);
   endtask

   task automatic finish_eq();
      @(negedge Clock);
      startEq = 1'b0;
   endtask

   // One Go submission held for `hold` cycles; optional Clear aligned with the CHECK edge.
   task automatic submit(input int data, input int hold, input bit clr,
                         input int exp_pulse, input int exp_tries, input int exp_wrong,
                         input string tag);
      int pulses, idx, w_at;
      pulses = 0; idx = -1; w_at = 0;
      @(negedge Clock);
      DataIn = 7'(data);
      Go = 1'b1;
      for (int k = 0; k < hold + 6; k++) begin
         @(posedge Clock); #1;
         if (correct === 1'b1) begin
            pulses++;
            if (idx < 0) idx = k;
            w_at = int'(Wrong);
         end
         if (k + 1 >= hold) Go = 1'b0;
         if (clr && k == 2) Clear = 1'b1;
         if (k == 3) Clear = 1'b0;
      end
      chk({tag, "_pulses"}, 32'(pulses), 32'(exp_pulse));
      if (exp_pulse != 0) begin
         chk({tag, "_latency"}, 32'(idx), 32'd3);
         chk({tag, "_wrong_with_correct"}, 32'(w_at), 32'(exp_wrong));
      end
      chk({tag, "_tries"}, 32'(Tries), 32'(exp_tries));
      chk({tag, "_wrong"}, 32'(Wrong), 32'(exp_wrong));
      chk({tag, "_eqvalid"}, 32'(EqValid), (exp_pulse != 0) ? 32'd0 : 32'd1);
   endtask

   typedef struct {
      int new_eq;
      int pred;
      int off;
      int hold;
      bit clr;
      int exp_pulse;
      int exp_tries;
      int exp_wrong;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int pulses;
      tbl[0] = '{new_eq: 1, pred: 0, off: 0, hold: 1,  clr: 0, exp_pulse: 1, exp_tries: 0, exp_wrong: 0};
      tbl[1] = '{new_eq: 1, pred: 1, off: 0, hold: 2,  clr: 0, exp_pulse: 1, exp_tries: 0, exp_wrong: 0};
      tbl[2] = '{new_eq: 1, pred: 0, off: 1, hold: 1,  clr: 0, exp_pulse: 0, exp_tries: 1, exp_wrong: 1};
      tbl[3] = '{new_eq: 0, pred: 0, off: 0, hold: 1,  clr: 0, exp_pulse: 1, exp_tries: 1, exp_wrong: 1};
      tbl[4] = '{new_eq: 1, pred: 0, off: 1, hold: 50, clr: 0, exp_pulse: 0, exp_tries: 1, exp_wrong: 1};
      tbl[5] = '{new_eq: 0, pred: 0, off: 2, hold: 1,  clr: 1, exp_pulse: 0, exp_tries: 2, exp_wrong: 1};
      tbl[6] = '{new_eq: 0, pred: 0, off: 3, hold: 3,  clr: 0, exp_pulse: 1, exp_tries: 3, exp_wrong: 1};

      Reset = 1'b1; startEq = 1'b0; Go = 1'b0; DataIn = 7'd0; Clear = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      chk("rst_operand_a", 32'(OperandA), 32'd0);
      chk("rst_operand_b", 32'(OperandB), 32'd0);
      chk("rst_op", 32'(Op), 32'd0);
      chk("rst_answer", 32'(Answer), 32'd0);
      chk("rst_eqvalid", 32'(EqValid), 32'd0);
      chk("rst_tries", 32'(Tries), 32'd0);
      chk("rst_correct", 32'(correct), 32'd0);
      chk("rst_wrong", 32'(Wrong), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;

      // Table-driven scenarios
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].new_eq != 0) begin
            finish_eq();
            start_eq(tbl[i].pred);
         end
         submit(exp_ans + tbl[i].off, tbl[i].hold, tbl[i].clr, tbl[i].exp_pulse,
                tbl[i].exp_tries, tbl[i].exp_wrong, $sformatf("tbl%0d", i));
      end

      // Clear on its own drops the sticky flag.
      @(negedge Clock);
      Clear = 1'b1;
      @(posedge Clock); #1;
      chk("clear_alone", 32'(Wrong), 32'd0);
      Clear = 1'b0;

      // Abort while the wrong answer is in CHECK: no pulse, Wrong and Tries untouched.
      finish_eq();
      start_eq(0);
      @(negedge Clock);
      DataIn = 7'(exp_ans + 1);
      Go = 1'b1;
      @(posedge Clock); #1;
      Go = 1'b0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      startEq = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge Clock); #1;
         if (correct === 1'b1) pulses++;
      end
      chk("abort_check_pulses", 32'(pulses), 32'd0);
      chk("abort_check_wrong", 32'(Wrong), 32'd0);
      chk("abort_check_tries", 32'(Tries), 32'd0);
      chk("abort_check_eqvalid", 32'(EqValid), 32'd0);

      // Abort in WAIT takes effect on the next edge.
      start_eq(0);
      @(negedge Clock);
      startEq = 1'b0;
      @(posedge Clock); #1;
      chk("abort_wait_eqvalid", 32'(EqValid), 32'd0);
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge Clock); #1;
         if (correct === 1'b1) pulses++;
      end
      chk("abort_wait_pulses", 32'(pulses), 32'd0);

      // Asynchronous reset between edges while waiting, after a wrong attempt.
      start_eq(0);
      submit(exp_ans + 5, 1, 0, 0, 1, 1, "pre_reset");
      @(posedge Clock); #3;
      Reset = 1'b1;
      #1;
      chk("areset_operand_a", 32'(OperandA), 32'd0);
      chk("areset_answer", 32'(Answer), 32'd0);
      chk("areset_eqvalid", 32'(EqValid), 32'd0);
      chk("areset_tries", 32'(Tries), 32'd0);
      chk("areset_wrong", 32'(Wrong), 32'd0);
      chk("areset_correct", 32'(correct), 32'd0);
      chk("areset_lfsr", 32'(dut.lfsr_q), 32'(SEED));
      startEq = 1'b0;
      @(negedge Clock);
      Reset = 1'b0;
      m_wrong = 0;

      // Randomized equations against the reference model.
      for (int e = 0; e < 12; e++) begin
         bit passed;
         finish_eq();
         repeat ($urandom_range(0, 7)) @(negedge Clock);
         start_eq(0);
         passed = 0;
         for (int s = 0; s < MAX_TRIES + 2 && !passed; s++) begin
            int data, hold, expp;
            bit clr;
            if ($urandom_range(0, 2) == 0) data = exp_ans;
            else data = (exp_ans + int'($urandom_range(1, 40))) % 128;
            hold = int'($urandom_range(1, 5));
            clr = ($urandom_range(0, 3) == 0);
            expp = 0;
            if (data == exp_ans) begin
               expp = 1;
               if (clr) m_wrong = 0;
            end else begin
               m_tries++;
               m_wrong = 1;
               if (m_tries == MAX_TRIES) expp = 1;
            end
            submit(data, hold, clr, expp, m_tries, m_wrong, $sformatf("rnd%0d_%0d", e, s));
            if (expp != 0) passed = 1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
